// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures the gated control bundle from the ID-stage bubble mux together with
// the ID datapath values and presents them to EX one cycle later. Supports
// hold (stall), bubble insertion (flush) and slot-validity tracking.
// Update priority at each rising edge: rst > flush > stall > load.
// Optional macro BUBBLE_CNT_EN adds a saturating bubble_count output that
// counts the flush edges seen since reset.
module id_ex_reg #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  RegDst,
  input  logic                  RegWrite,
  input  logic                  aluSrc,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemToReg,
  input  logic [2:0]            aluOp,
  input  logic [WORD_W-1:0]     pc_in,
  input  logic [WORD_W-1:0]     rd1_in,
  input  logic [WORD_W-1:0]     rd2_in,
  input  logic [WORD_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  ex_RegDst,
  output logic                  ex_RegWrite,
  output logic                  ex_aluSrc,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_MemToReg,
  output logic [2:0]            ex_aluOp,
  output logic [WORD_W-1:0]     ex_pc,
  output logic [WORD_W-1:0]     ex_rd1,
  output logic [WORD_W-1:0]     ex_rd2,
  output logic [WORD_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_valid
`ifdef BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_count
`endif
);

  // Pipeline slot: reset and flush both leave an empty, all-zero slot; stall
  // holds; otherwise the ID values pass through bit-exact.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_RegDst   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_aluSrc   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemToReg <= 1'b0;
      ex_aluOp    <= '0;
      ex_pc       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_valid    <= 1'b0;
    end else if (!stall) begin
      ex_RegDst   <= RegDst;
      ex_RegWrite <= RegWrite;
      ex_aluSrc   <= aluSrc;
      ex_MemRead  <= MemRead;
      ex_MemWrite <= MemWrite;
      ex_MemToReg <= MemToReg;
      ex_aluOp    <= aluOp;
      ex_pc       <= pc_in;
      ex_rd1      <= rd1_in;
      ex_rd2      <= rd2_in;
      ex_imm      <= imm_in;
      ex_rs       <= rs_in;
      ex_rt       <= rt_in;
      ex_rd       <= rd_in;
      ex_valid    <= in_valid;
    end
  end

`ifdef BUBBLE_CNT_EN
  // Count flush edges (stall does not matter); stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (flush && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed literal checks followed by
// randomized stimulus compared every cycle against a slot-level reference model.
module tb_id_ex_reg;
  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, stall, flush, in_valid;
  logic RegDst, RegWrite, aluSrc, MemRead, MemWrite, MemToReg;
  logic [2:0] aluOp;
  logic [WORD_W-1:0] pc_in, rd1_in, rd2_in, imm_in;
  logic [REG_ADDR_W-1:0] rs_in, rt_in, rd_in;
  logic ex_RegDst, ex_RegWrite, ex_aluSrc, ex_MemRead, ex_MemWrite, ex_MemToReg;
  logic [2:0] ex_aluOp;
  logic [WORD_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic ex_valid;
`ifdef BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .RegDst(RegDst), .RegWrite(RegWrite), .aluSrc(aluSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .aluOp(aluOp),
    .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .ex_RegDst(ex_RegDst), .ex_RegWrite(ex_RegWrite), .ex_aluSrc(ex_aluSrc),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
    .ex_aluOp(ex_aluOp), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid)
`ifdef BUBBLE_CNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  // Bundled views of the instruction slot: control, data, specifiers.
  wire [8:0]   inCtl   = {RegDst, RegWrite, aluSrc, MemRead, MemWrite, MemToReg, aluOp};
  wire [127:0] inData  = {pc_in, rd1_in, rd2_in, imm_in};
  wire [14:0]  inSpec  = {rs_in, rt_in, rd_in};
  wire [8:0]   dutCtl  = {ex_RegDst, ex_RegWrite, ex_aluSrc, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_aluOp};
  wire [127:0] dutData = {ex_pc, ex_rd1, ex_rd2, ex_imm};
  wire [14:0]  dutSpec = {ex_rs, ex_rt, ex_rd};

  // Reference model: the EX slot is either empty (after rst/flush), the
  // previous slot (stall) or a copy of the ID slot; the counter tallies flushes.
  logic [8:0]   expCtl;
  logic [127:0] expData;
  logic [14:0]  expSpec;
  logic         expValid;
  int           expCnt = 0;
  bit           modelLive = 1'b0;
  bit           cmpEn = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      expCtl = '0; expData = '0; expSpec = '0; expValid = 1'b0;
      expCnt = 0;
      modelLive = 1'b1;
    end else if (flush) begin
      expCtl = '0; expData = '0; expSpec = '0; expValid = 1'b0;
      expCnt = (expCnt < CNT_MAX) ? expCnt + 1 : CNT_MAX;
    end else if (!stall) begin
      expCtl = inCtl; expData = inData; expSpec = inSpec; expValid = in_valid;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model once it has seen a reset.
  always @(negedge clk) begin
    if (cmpEn && modelLive) begin
      chk("model_ctl", {119'd0, dutCtl}, {119'd0, expCtl});
      chk("model_data", dutData, expData);
      chk("model_spec", {113'd0, dutSpec}, {113'd0, expSpec});
      chk("model_valid", {127'd0, ex_valid}, {127'd0, expValid});
`ifdef BUBBLE_CNT_EN
      chk("model_bubble_count", {124'd0, bubble_count}, 128'(expCnt));
`endif
    end
  end

  // Advance one edge; return #1 after the following negedge compare.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic setAll(input logic v);
    in_valid = v; RegDst = v; RegWrite = v; aluSrc = v; MemRead = v; MemWrite = v; MemToReg = v;
    aluOp = {3{v}}; pc_in = {WORD_W{v}}; rd1_in = {WORD_W{v}}; rd2_in = {WORD_W{v}};
    imm_in = {WORD_W{v}}; rs_in = {REG_ADDR_W{v}}; rt_in = {REG_ADDR_W{v}}; rd_in = {REG_ADDR_W{v}};
  endtask

  task automatic randIn();
    in_valid = 1'($urandom); RegDst = 1'($urandom); RegWrite = 1'($urandom);
    aluSrc = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
    MemToReg = 1'($urandom); aluOp = 3'($urandom);
    pc_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
    rs_in = 5'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
    rst   = ($urandom_range(0, 99) < 3);
    flush = ($urandom_range(0, 99) < 12);
    stall = ($urandom_range(0, 99) < 30);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    setAll(1'b1);
    @(negedge clk);
    cmpEn = 1'b1;

    // Reset with all inputs non-zero for two edges.
    tick(); tick();
    chk("reset_ex_pc", 128'(ex_pc), 128'd0);
    chk("reset_ex_valid", 128'(ex_valid), 128'd0);
    chk("reset_ctl", 128'(dutCtl), 128'd0);
`ifdef BUBBLE_CNT_EN
    chk("reset_bubble_count", 128'(bubble_count), 128'd0);
`endif

    // Plain load.
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    setAll(1'b0);
    in_valid = 1'b1; RegWrite = 1'b1; aluOp = 3'b010;
    pc_in = 32'h0000_0010; rd1_in = 32'hDEAD_BEEF; rt_in = 5'd9;
    tick();
    chk("load_ex_RegWrite", 128'(ex_RegWrite), 128'd1);
    chk("load_ex_aluOp", 128'(ex_aluOp), 128'(3'b010));
    chk("load_ex_pc", 128'(ex_pc), 128'h10);
    chk("load_ex_rd1", 128'(ex_rd1), 128'hDEADBEEF);
    chk("load_ex_rt", 128'(ex_rt), 128'd9);
    chk("load_ex_valid", 128'(ex_valid), 128'd1);

    // Hold for three edges while the ID values move on.
    stall = 1'b1; pc_in = 32'h0000_0014;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ex_pc", 128'(ex_pc), 128'h10);
      chk("stall_ex_valid", 128'(ex_valid), 128'd1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_ex_pc", 128'(ex_pc), 128'h14);

    // Flush beats a simultaneous stall.
    flush = 1'b1; stall = 1'b1;
    tick();
    chk("flush_ctl", 128'(dutCtl), 128'd0);
    chk("flush_ex_valid", 128'(ex_valid), 128'd0);
    chk("flush_ex_rd1", 128'(ex_rd1), 128'd0);
`ifdef BUBBLE_CNT_EN
    chk("flush_bubble_count", 128'(bubble_count), 128'd1);
`endif

    // Reset beats flush and stall; the counter is cleared, not bumped.
    flush = 1'b0; stall = 1'b0; setAll(1'b1);
    tick();
    rst = 1'b1; flush = 1'b1; stall = 1'b1;
    tick();
    chk("rstprio_data", dutData, 128'd0);
    chk("rstprio_ctl", 128'(dutCtl), 128'd0);
    chk("rstprio_ex_valid", 128'(ex_valid), 128'd0);
`ifdef BUBBLE_CNT_EN
    chk("rstprio_bubble_count", 128'(bubble_count), 128'd0);
`endif

    // Twenty consecutive flushes saturate a 4-bit counter.
    rst = 1'b0; flush = 1'b1; stall = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_ex_valid", 128'(ex_valid), 128'd0);
`ifdef BUBBLE_CNT_EN
    chk("sat_bubble_count", 128'(bubble_count), 128'd15);
    tick();
    chk("sat_hold_bubble_count", 128'(bubble_count), 128'd15);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      randIn();
      tick();
    end

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
